// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter: round-robin arbiter that serialises load/preset/clear/hold
// operations from N_REQ requesters onto one shared WIDTH-bit register.
// Every transaction runs IDLE -> EXEC -> ACK and takes exactly three cycles.
module reg_access_arbiter #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [2*N_REQ-1:0]     i_op,
    input  logic [WIDTH*N_REQ-1:0] i_data,
    output logic [N_REQ-1:0]       o_grant,
    output logic [N_REQ-1:0]       o_ack,
    output logic                   o_busy,
    output logic [WIDTH-1:0]       o_Q
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [IDX_W:0]   N_REQ_W = (IDX_W + 1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_PRESET = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_HOLD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        ACK  = 2'b10
    } state_t;

    state_t             state_reg, state_next;
    logic [N_REQ-1:0]   grant_reg, grant_next;
    logic [N_REQ-1:0]   ack_reg, ack_next;
    logic               busy_reg, busy_next;
    logic [WIDTH-1:0]   q_reg, q_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]   winner_reg, winner_next;

    // Per-requester views of the flattened op/data buses.
    logic [1:0]         op_arr   [N_REQ];
    logic [WIDTH-1:0]   data_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign op_arr[gi]   = i_op[2*gi +: 2];
            assign data_arr[gi] = i_data[WIDTH*gi +: WIDTH];
        end
    endgenerate

    // Round-robin pick: first requesting index at or above rr_ptr, wrapping.
    logic [IDX_W-1:0] pick;
    logic             pick_found;
    logic [IDX_W:0]   pick_sum;

    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        pick_sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pick_sum = {1'b0, rr_ptr_reg} + (IDX_W + 1)'(i);
            if (pick_sum >= N_REQ_W) begin
                pick_sum = pick_sum - N_REQ_W;
            end
            if (!pick_found && i_req[pick_sum[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick       = pick_sum[IDX_W-1:0];
            end
        end
    end

    // Next-state and datapath logic for the three-state sequencer.
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        ack_next    = ack_reg;
        q_next      = q_reg;
        rr_ptr_next = rr_ptr_reg;
        winner_next = winner_reg;

        case (state_reg)
            IDLE: begin
                grant_next = '0;
                ack_next   = '0;
                if (pick_found) begin
                    winner_next = pick;
                    grant_next  = N_REQ'(1) << pick;
                    state_next  = EXEC;
                end
            end
            EXEC: begin
                // Only the granted requester's op/data reach the register.
                case (op_arr[winner_reg])
                    OP_LOAD:   q_next = data_arr[winner_reg];
                    OP_PRESET: q_next = '1;
                    OP_CLEAR:  q_next = '0;
                    OP_HOLD:   q_next = q_reg;
                    default:   q_next = q_reg;
                endcase
                ack_next    = grant_reg;
                rr_ptr_next = (winner_reg == LAST_IDX) ? '0 : winner_reg + 1'b1;
                state_next  = ACK;
            end
            ACK: begin
                // Requests are deliberately not sampled here.
                ack_next   = '0;
                grant_next = '0;
                state_next = IDLE;
            end
            default: begin
                ack_next   = '0;
                grant_next = '0;
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            ack_reg    <= '0;
            busy_reg   <= 1'b0;
            q_reg      <= '0;
            rr_ptr_reg <= '0;
            winner_reg <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            ack_reg    <= ack_next;
            busy_reg   <= busy_next;
            q_reg      <= q_next;
            rr_ptr_reg <= rr_ptr_next;
            winner_reg <= winner_next;
        end
    end

    assign o_grant = grant_reg;
    assign o_ack   = ack_reg;
    assign o_busy  = busy_reg;
    assign o_Q     = q_reg;

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
Round-robin arbiter and sequencer that shares one WIDTH-bit storage register (a bank of D flip-flops with load/preset/clear semantics) among N_REQ requesters. Each requester presents an operation and data under a req/ack handshake. The block grants one requester at a time and applies its operation to the register. It sits between several control agents and a single shared state register, so none of them drive the flip-flops directly.

Parameters:
WIDTH, 8, register width in bits (1..32)
N_REQ, 4, number of requesters (2..8)

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous reset, active-high
i_req  input  N_REQ  per-requester request level
i_op  input  2*N_REQ  per-requester op, requester k at bits [2k+1:2k]; 00 load, 01 preset, 10 clear, 11 hold
i_data  input  WIDTH*N_REQ  per-requester load data, requester k at bits [WIDTH*k+WIDTH-1:WIDTH*k]
o_grant  output  N_REQ  registered one-hot grant; all zero when idle
o_ack  output  N_REQ  one-cycle completion pulse to the granted requester
o_busy  output  1  high whenever state is not IDLE
o_Q  output  WIDTH  shared register contents

Behaviour:
- Reset (i_rst=1 at a rising edge), which overrides everything:
  - state=IDLE, o_Q=0, o_grant=0, o_ack=0, o_busy=0, rr pointer=0.
  - Reset mid-transaction aborts it: no ack, o_Q forced to 0.
- FSM states: IDLE, EXEC, ACK. Each transaction takes exactly 3 cycles. Peak throughput is one op per 3 cycles.
- IDLE:
  - If i_req != 0, select the winner: the first set bit searching upward from the rr pointer, wrapping from N_REQ-1 to 0.
  - Register o_grant = onehot(winner) and go to EXEC.
  - If i_req == 0, stay in IDLE; o_grant remains 0.
- EXEC:
  - o_grant holds the winner.
  - At the end of the cycle, sample the winner's i_op and i_data and update o_Q:
    - load: o_Q <= data.
    - preset: o_Q <= all ones.
    - clear: o_Q <= all zeros.
    - hold: o_Q unchanged.
  - On the same edge: o_ack[winner] <= 1, rr pointer <= (winner+1) mod N_REQ, go to ACK.
- ACK:
  - o_ack[winner]=1 for exactly this cycle; o_Q already shows the new value; o_grant still holds the winner.
  - On the next edge: o_ack <= 0, o_grant <= 0, go to IDLE. i_req is not sampled in ACK.
- Requester protocol:
  - Raise req and hold req/op/data stable until ack is seen.
  - Drop req at the edge that ends the ack cycle.
  - Req still high in the following IDLE cycle counts as a new request.
- Protocol violation: req dropped during EXEC/ACK. The transaction still completes with the op/data sampled at the end of EXEC, and ack is still issued.
- Only the granted requester's op/data can affect o_Q. Non-granted inputs are ignored.
- Fairness: a continuously requesting agent waits at most N_REQ-1 transactions.
- Simultaneous requests in IDLE: exactly one is granted, chosen by rr pointer order. The others remain pending with no ack.
- Invariants:
  - o_grant and o_ack are each zero or one-hot.
  - o_ack is set only in the bit where o_grant is set.
  - o_busy = (state != IDLE), registered.

Test Plan:
1. Reset then idle: hold i_rst=1 for 2 cycles, then i_req=0 for 10 cycles -> o_Q=0x00, o_grant=0, o_ack=0, o_busy=0 throughout.
2. Single load: req0, op=00, data=0xA5 -> o_grant=0001 in cycle 1, o_Q=0xA5 and o_ack=0001 in cycle 2, o_grant=0 and o_busy=0 in cycle 3.
3. Preset/clear/hold sequence from req2:
   - preset -> o_Q=0xFF.
   - clear -> o_Q=0x00.
   - load 0x3C then hold -> o_Q stays 0x3C.
   - Each op acks once.
4. Round robin with all four reqs held high, each loading its index+1 and dropping then re-raising req after ack -> grant order 0,1,2,3,0; o_Q takes 0x01,0x02,0x03,0x04,0x01.
5. Wrap and skip: rr pointer=3 (after grant to 2), reqs {0,1} high -> grant to 0, then 1; requester 3 is never granted.
6. Reset mid-op: assert i_rst in the EXEC cycle of a load 0x55 -> no ack, o_Q=0x00, state IDLE; after release, a pending req0 is granted normally.
